// File: rtl/cnn_conv_sched.sv
// Convolution scheduler: counts the 48-beat load burst into the buffers, then walks the
// MAC through 16 pixels x 27 taps with padding, drains the pipeline and hands off to post.
module cnn_conv_sched #(
  parameter int unsigned MAC_LAT = 4,
  parameter int unsigned POST_TO = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] opt_in,
  output logic [5:0] ld_idx,
  output logic       img_we,
  output logic       ker_we,
  output logic       wgt_we,
  output logic [1:0] opt_q,
  output logic       mac_vld,
  input  logic       mac_rdy,
  output logic [5:0] img_addr,
  output logic [4:0] ker_addr,
  output logic       pad_zero,
  output logic       mac_first,
  output logic       mac_last,
  output logic [3:0] pix_addr,
  output logic       post_start,
  input  logic       post_busy,
  output logic       busy
);

  localparam int unsigned DrainW = $clog2(MAC_LAT + 1);
  localparam int unsigned PostW  = $clog2(POST_TO + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StConv, StDrain, StPost} state_e;

  state_e              state_q;
  logic [5:0]          cnt_q;
  logic [3:0]          pix_q;
  logic [1:0]          ch_q, kr_q, kc_q;
  logic [DrainW-1:0]   drain_q;
  logic [PostW-1:0]    post_q;
  logic                mac_vld_q;
  logic                post_start_q;

  logic                load_en;
  logic [2:0]          row_s, col_s;
  logic                row_oob, col_oob, pad;
  logic [1:0]          ir, ic;

  assign load_en    = (state_q == StIdle) || (state_q == StLoad);
  assign img_we     = in_valid & load_en;
  assign ker_we     = img_we & (cnt_q < 6'd27);
  assign wgt_we     = img_we & (cnt_q < 6'd4);
  assign ld_idx     = cnt_q;
  assign mac_vld    = mac_vld_q;
  assign post_start = post_start_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      opt_q        <= '0;
      pix_q        <= '0;
      ch_q         <= '0;
      kr_q         <= '0;
      kc_q         <= '0;
      drain_q      <= '0;
      post_q       <= '0;
      mac_vld_q    <= 1'b0;
      post_start_q <= 1'b0;
    end else begin
      post_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StLoad;
            cnt_q   <= 6'd1;
            opt_q   <= opt_in;
          end
        end
        StLoad: begin
          if (in_valid) begin
            if (cnt_q == 6'd47) begin
              state_q   <= StConv;
              cnt_q     <= '0;
              mac_vld_q <= 1'b1;
              pix_q     <= '0;
              ch_q      <= '0;
              kr_q      <= '0;
              kc_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        StConv: begin
          // Tap counters nest kc -> kr -> ch -> pix; everything holds while mac_rdy=0.
          if (mac_rdy) begin
            if (kc_q != 2'd2) begin
              kc_q <= kc_q + 2'd1;
            end else begin
              kc_q <= '0;
              if (kr_q != 2'd2) begin
                kr_q <= kr_q + 2'd1;
              end else begin
                kr_q <= '0;
                if (ch_q != 2'd2) begin
                  ch_q <= ch_q + 2'd1;
                end else begin
                  ch_q <= '0;
                  if (pix_q != 4'd15) begin
                    pix_q <= pix_q + 4'd1;
                  end else begin
                    pix_q     <= '0;
                    state_q   <= StDrain;
                    mac_vld_q <= 1'b0;
                    drain_q   <= '0;
                  end
                end
              end
            end
          end
        end
        StDrain: begin
          // post_start lands MAC_LAT cycles after the final issue.
          if (drain_q == DrainW'(MAC_LAT - 2)) begin
            state_q      <= StPost;
            post_start_q <= 1'b1;
            post_q       <= '0;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StPost: begin
          post_q <= post_q + 1'b1;
          // post_busy is not yet meaningful in the post_start cycle.
          if ((!post_start_q && !post_busy) || (post_q == PostW'(POST_TO - 1))) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    row_s   = {1'b0, pix_q[3:2]} + {1'b0, kr_q};
    col_s   = {1'b0, pix_q[1:0]} + {1'b0, kc_q};
    row_oob = (row_s == 3'd0) || (row_s > 3'd4);
    col_oob = (col_s == 3'd0) || (col_s > 3'd4);
    ir      = (row_s == 3'd0) ? 2'd0 : (row_s > 3'd4) ? 2'd3 : 2'(row_s - 3'd1);
    ic      = (col_s == 3'd0) ? 2'd0 : (col_s > 3'd4) ? 2'd3 : 2'(col_s - 3'd1);
    pad     = mac_vld_q & opt_q[0] & (row_oob | col_oob);

    pad_zero  = pad;
    img_addr  = (mac_vld_q && !pad) ? {ch_q, ir, ic} : 6'd0;
    ker_addr  = mac_vld_q ? (5'(ch_q) * 5'd9 + 5'(kr_q) * 5'd3 + 5'(kc_q)) : 5'd0;
    mac_first = mac_vld_q & (ch_q == 2'd0) & (kr_q == 2'd0) & (kc_q == 2'd0);
    mac_last  = mac_vld_q & (ch_q == 2'd2) & (kr_q == 2'd2) & (kc_q == 2'd2);
    pix_addr  = mac_vld_q ? pix_q : 4'd0;
  end

endmodule

// File: tb/tb_cnn_conv_sched.sv
// Directed bench for cnn_conv_sched: expected MAC issues are queued when a burst is driven
// and popped on every accepted issue.
module tb_cnn_conv_sched;

  logic       clk = 1'b0;
  logic       rst, in_valid, mac_rdy, post_busy;
  logic [1:0] opt_in;
  logic [5:0] ld_idx, img_addr;
  logic       img_we, ker_we, wgt_we, mac_vld, pad_zero, mac_first, mac_last, post_start, busy;
  logic [1:0] opt_q;
  logic [4:0] ker_addr;
  logic [3:0] pix_addr;

  cnn_conv_sched #(.MAC_LAT(4), .POST_TO(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .opt_in     (opt_in),
    .ld_idx     (ld_idx),
    .img_we     (img_we),
    .ker_we     (ker_we),
    .wgt_we     (wgt_we),
    .opt_q      (opt_q),
    .mac_vld    (mac_vld),
    .mac_rdy    (mac_rdy),
    .img_addr   (img_addr),
    .ker_addr   (ker_addr),
    .pad_zero   (pad_zero),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .pix_addr   (pix_addr),
    .post_start (post_start),
    .post_busy  (post_busy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nchk = 0;
  int          nerr = 0;
  logic [17:0] exp_q[$];
  int          fires, conv_cyc;
  bit          done;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // {img_addr, ker_addr, pad_zero, mac_first, mac_last, pix_addr}
  function automatic logic [17:0] exp_issue(int p, int ch, int kr, int kc, bit zero);
    int   ir = p / 4 + kr - 1;
    int   ic = p % 4 + kc - 1;
    int   ia;
    logic pz;
    if (zero && (ir < 0 || ir > 3 || ic < 0 || ic > 3)) begin
      pz = 1'b1;
      ia = 0;
    end else begin
      pz = 1'b0;
      if (ir < 0) ir = 0;
      if (ir > 3) ir = 3;
      if (ic < 0) ic = 0;
      if (ic > 3) ic = 3;
      ia = ch * 16 + ir * 4 + ic;
    end
    return {6'(ia), 5'(ch * 9 + kr * 3 + kc), pz, 1'(ch == 0 && kr == 0 && kc == 0),
            1'(ch == 2 && kr == 2 && kc == 2), 4'(p)};
  endfunction

  task automatic load_burst(input logic [1:0] opt, input int gap_at, input int gap_len);
    for (int p = 0; p < 16; p++)
      for (int ch = 0; ch < 3; ch++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            exp_q.push_back(exp_issue(p, ch, kr, kc, opt[0]));
    for (int b = 0; b < 48; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          opt_in   = ~opt;
          @(negedge clk);
          chk("gap_ld_idx", ld_idx, b);
          chk("gap_img_we", img_we, 0);
          chk("gap_busy", busy, 1);
          chk("gap_mac_vld", mac_vld, 0);
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      opt_in   = (b == 0) ? opt : ~opt;
      @(negedge clk);
      chk("ld_idx", ld_idx, b);
      chk("img_we", img_we, 1);
      chk("ker_we", ker_we, (b < 27));
      chk("wgt_we", wgt_we, (b < 4));
      chk("load_mac_vld", mac_vld, 0);
      if (b == 1) chk("opt_q", opt_q, opt);
    end
  endtask

  task automatic run_conv(input bit toggle, input int abort_at);
    logic [17:0] cur, snap, e;
    bit          stalled = 0;
    bit          rdy_ph = 0;
    int          last_fire = 0;
    fires    = 0;
    conv_cyc = 0;
    done     = 0;
    snap     = '0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mac_rdy  = toggle ? rdy_ph : 1'b1;
      rdy_ph   = ~rdy_ph;
      @(negedge clk);
      cur = {img_addr, ker_addr, pad_zero, mac_first, mac_last, pix_addr};
      if (i == 0) chk("first_mac_vld", mac_vld, 1);
      if (stalled) chk("frozen", {mac_vld, cur}, {1'b1, snap});
      stalled = 0;
      if (mac_vld) begin
        conv_cyc++;
        if (!mac_rdy) begin
          stalled = 1;
          snap    = cur;
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          chk("issue", cur, e);
          fires++;
          last_fire = cyc;
          if (fires == abort_at) return;
        end
      end else begin
        chk("idle_addr", cur, 0);
      end
      if (post_start) begin
        chk("post_start_lat", cyc - last_fire, 4);
        done = 1;
      end
    end
    chk("post_start_seen", done, 1);
    chk("fires", fires, 432);
    chk("conv_cycles", conv_cyc, toggle ? 864 : 432);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic finish_post();
    bit idle = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      post_busy = 1'b1;
      @(negedge clk);
      chk("post_hold_busy", busy, 1);
      chk("post_start_pulse", post_start, 0);
    end
    @(posedge clk); #1;
    post_busy = 1'b0;
    for (int i = 0; i < 5 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    chk("post_to_idle", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    opt_in    = 2'b00;
    mac_rdy   = 1'b1;
    post_busy = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mac_vld", mac_vld, 0);
    chk("rst_post_start", post_start, 0);
    chk("rst_ld_idx", ld_idx, 0);
    chk("rst_opt_q", opt_q, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero padding: first issue is a padded tap.
    load_burst(2'b01, -1, 0);
    chk("opt_q_held", opt_q, 2'b01);
    run_conv(1'b0, 0);
    finish_post();

    // Replicate padding, no backpressure.
    load_burst(2'b00, -1, 0);
    run_conv(1'b0, 0);
    finish_post();

    // Alternating backpressure.
    load_burst(2'b00, -1, 0);
    run_conv(1'b1, 0);
    finish_post();

    // Input gap mid-burst.
    load_burst(2'b01, 20, 5);
    run_conv(1'b0, 0);
    finish_post();

    // Reset mid-convolution, then a clean pattern.
    load_burst(2'b00, -1, 0);
    run_conv(1'b0, 200);
    chk("abort_fires", fires, 200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_mac_vld", mac_vld, 0);
    chk("abort_ld_idx", ld_idx, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_post", post_start, 0);
    end
    load_burst(2'b01, -1, 0);
    run_conv(1'b0, 0);
    finish_post();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
